// File: rtl/mvm_pkg.sv
// Shared types and helpers for the tiled signed matrix-vector multiplier.
// Holds the controller state encoding and the shift-then-clamp requantiser.
package mvm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_WRITE = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Requantiser result: clamp flag plus the (sign-extended) output value.
  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } sat_res_t;

  // Arithmetic right shift by 'shift', then clamp to a signed out_w-bit range.
  // Widths up to 64 bits; the caller truncates val to its own output width.
  function automatic sat_res_t sat_shift(input logic signed [63:0] acc,
                                         input int unsigned        shift,
                                         input int unsigned        out_w);
    logic signed [63:0] v_s;
    logic signed [63:0] max_s;
    logic signed [63:0] min_s;
    sat_res_t           r;
    v_s   = acc >>> shift;
    max_s = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    min_s = -(64'sd1 <<< (out_w - 32'd1));
    if (v_s > max_s) begin
      r.sat = 1'b1;
      r.val = max_s;
    end else if (v_s < min_s) begin
      r.sat = 1'b1;
      r.val = min_s;
    end else begin
      r.sat = 1'b0;
      r.val = v_s;
    end
    return r;
  endfunction

endpackage

// File: rtl/mvm_tiled_mac_lane.sv
// Single signed MAC lane: loads an initial value on clr_i, otherwise adds the
// full-precision product a_i*b_i (sign-extended) when acc_en_i is high.
// The accumulator wraps modulo 2^ACC_WIDTH.
module mac_lane #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clr_i,
  input  logic                        acc_en_i,
  input  logic signed [ACC_WIDTH-1:0] init_i,
  input  logic signed [WIDTH-1:0]     a_i,
  input  logic signed [WIDTH-1:0]     b_i,
  output logic signed [ACC_WIDTH-1:0] acc_o
);

  logic signed [2*WIDTH-1:0]   prod_s;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] acc_q;

  // Next accumulator value: init-load has priority over accumulate.
  always_comb begin
    prod_s = a_i * b_i;
    if (clr_i) begin
      acc_d = init_i;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_WIDTH'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mvm_tiled.sv
// Tiled signed matrix-vector multiplier y = M*x with LANES parallel MAC lanes.
// Rows are processed in ROWS/LANES tiles of COLS accumulate cycles plus one
// write cycle; each element is requantised (>>> SHIFT, then clamp).
// Optional feature: define MVM_BIAS_EN to add a per-row bias input that
// preloads the accumulators at the start of every tile.
module mvm_tiled
  import mvm_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 4,
  parameter int LANES     = 4,
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ROWS*COLS*WIDTH-1:0]      matrix,
  input  logic [COLS*WIDTH-1:0]           vector,
`ifdef MVM_BIAS_EN
  input  logic [ROWS*WIDTH-1:0]           bias,
`endif
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ROWS*OUT_WIDTH-1:0]       result_vector,
  output logic                            saturated
);

  localparam int TILES = ROWS / LANES;
  localparam int TW    = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

  if (((ROWS % LANES) != 0) || (ACC_WIDTH < 2 * WIDTH)) begin : g_bad_params
    $error("mvm_tiled: illegal parameters (LANES must divide ROWS, ACC_WIDTH >= 2*WIDTH)");
  end

  state_e                     state_q;
  logic [TW-1:0]              tile_q;
  logic [CW-1:0]              col_q;
  logic [ROWS*COLS*WIDTH-1:0] mat_q;
  logic [COLS*WIDTH-1:0]      vec_q;
`ifdef MVM_BIAS_EN
  logic [ROWS*WIDTH-1:0]      bias_q;
`endif
  logic [ROWS*OUT_WIDTH-1:0]  res_q;
  logic                       sat_q;
  logic                       in_ready_q;
  logic                       out_valid_q;

  logic                        accept_s;
  logic                        clr_s;
  logic                        en_s;
  logic                        last_tile_s;
  logic signed [WIDTH-1:0]     x_s;
  logic signed [WIDTH-1:0]     a_s    [LANES];
  logic signed [ACC_WIDTH-1:0] init_s [LANES];
  logic signed [ACC_WIDTH-1:0] acc_s  [LANES];
  logic [OUT_WIDTH-1:0]        wr_val_s [LANES];
  logic                        wr_sat_s;

  // Lane control, operand selection, accumulator init values and requantisation.
  always_comb begin
    int       row_v;
    sat_res_t res_v;
    row_v       = 0;
    res_v       = '0;
    accept_s    = (state_q == ST_IDLE) && in_valid && in_ready_q;
    clr_s       = accept_s || (state_q == ST_WRITE);
    en_s        = (state_q == ST_ACCUM);
    last_tile_s = (tile_q == TW'(TILES - 1));
    x_s         = vec_q[WIDTH*(COLS - int'(col_q)) - 1 -: WIDTH];
    wr_sat_s    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      row_v    = int'(tile_q) * LANES + l;
      a_s[l]   = mat_q[WIDTH*(ROWS*COLS - row_v*COLS - int'(col_q)) - 1 -: WIDTH];
      res_v    = sat_shift(64'(acc_s[l]), SHIFT, OUT_WIDTH);
      wr_val_s[l] = OUT_WIDTH'(res_v.val);
      wr_sat_s = wr_sat_s | res_v.sat;
`ifdef MVM_BIAS_EN
      if (accept_s) begin
        init_s[l] = ACC_WIDTH'($signed(bias[WIDTH*(ROWS - l) - 1 -: WIDTH]));
      end else if ((state_q == ST_WRITE) && !last_tile_s) begin
        init_s[l] = ACC_WIDTH'($signed(bias_q[WIDTH*(ROWS - row_v - LANES) - 1 -: WIDTH]));
      end else begin
        init_s[l] = '0;
      end
`else
      init_s[l] = '0;
`endif
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .WIDTH     (WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr_i    (clr_s),
      .acc_en_i (en_s),
      .init_i   (init_s[l]),
      .a_i      (a_s[l]),
      .b_i      (x_s),
      .acc_o    (acc_s[l])
    );
  end

  // Controller FSM with operand capture, tile/column counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tile_q      <= '0;
      col_q       <= '0;
      mat_q       <= '0;
      vec_q       <= '0;
`ifdef MVM_BIAS_EN
      bias_q      <= '0;
`endif
      res_q       <= '0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            mat_q      <= matrix;
            vec_q      <= vector;
`ifdef MVM_BIAS_EN
            bias_q     <= bias;
`endif
            sat_q      <= 1'b0;
            tile_q     <= '0;
            col_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_ACCUM;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (col_q == CW'(COLS - 1)) begin
            col_q   <= '0;
            state_q <= ST_WRITE;
          end else begin
            col_q   <= col_q + CW'(1);
          end
        end
        ST_WRITE: begin
          for (int l = 0; l < LANES; l++) begin
            res_q[OUT_WIDTH*(ROWS - (int'(tile_q)*LANES + l)) - 1 -: OUT_WIDTH] <= wr_val_s[l];
          end
          sat_q <= sat_q | wr_sat_s;
          if (last_tile_s) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else begin
            tile_q      <= tile_q + TW'(1);
            state_q     <= ST_ACCUM;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign result_vector = res_q;
  assign saturated     = sat_q;

endmodule

// File: tb/tb_mvm_tiled.sv
// Directed self-checking bench for mvm_tiled at default parameters.
// Build with MVM_BIAS_EN defined to exercise the bias port.
module tb_mvm_tiled;

  localparam int ROWS  = 8;
  localparam int COLS  = 4;
  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic        saturated;
  logic [255:0] matrix = '0;
  logic [31:0]  vector = '0;
  logic [63:0]  result_vector;
`ifdef MVM_BIAS_EN
  logic [63:0]  bias = '0;
`endif

  int checks = 0;
  int failures = 0;

  localparam logic [63:0] ID_EXP  = {8'd1, 8'd2, 8'd3, 8'd4, 32'd0};
  localparam logic [63:0] POS_EXP = {8{8'h7f}};
  localparam logic [63:0] NEG_EXP = {8{8'h80}};

  always #5 clk = ~clk;

  mvm_tiled u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .matrix        (matrix),
    .vector        (vector),
`ifdef MVM_BIAS_EN
    .bias          (bias),
`endif
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result_vector (result_vector),
    .saturated     (saturated)
  );

  task automatic set_m(input int r, input int c, input logic [7:0] v);
    matrix[WIDTH*(ROWS*COLS - r*COLS - c) - 1 -: WIDTH] = v;
  endtask

  task automatic load_identity();
    matrix = '0;
    for (int r = 0; r < 4; r++) set_m(r, r, 8'd1);
    vector = {8'd16, 8'd32, 8'd48, 8'd64};
  endtask

  task automatic load_fill(input logic [7:0] mv, input logic [7:0] xv);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) set_m(r, c, mv);
    vector = {4{xv}};
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic do_accept();
    wait_ready();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result_vector !== 64'd0 || saturated !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h sat=%b, required 1 0 0 0",
               in_ready, out_valid, result_vector, saturated);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_identity();
    int lat;
    out_ready = 1'b1;
    load_identity();
    do_accept();
    wait_out(lat);
    checks++;
    if (lat !== 10) begin
      failures++;
      $display("FAIL identity_latency: got %0d, required 10", lat);
    end
    checks++;
    if (result_vector !== ID_EXP || saturated !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL identity_result: result=%h sat=%b in_ready=%b, required %h 0 0",
               result_vector, saturated, in_ready, ID_EXP);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL identity_return_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturate();
    int lat;
    load_fill(8'd127, 8'd127);
    do_accept();
    wait_out(lat);
    checks++;
    if (lat !== 10 || result_vector !== POS_EXP || saturated !== 1'b1) begin
      failures++;
      $display("FAIL sat_positive: lat=%0d result=%h sat=%b, required 10 %h 1",
               lat, result_vector, saturated, POS_EXP);
    end
    consume();
    load_fill(8'h80, 8'd127);
    do_accept();
    wait_out(lat);
    checks++;
    if (lat !== 10 || result_vector !== NEG_EXP || saturated !== 1'b1) begin
      failures++;
      $display("FAIL sat_negative: lat=%0d result=%h sat=%b, required 10 %h 1",
               lat, result_vector, saturated, NEG_EXP);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    load_identity();
    do_accept();
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      load_fill(8'd127, 8'd127);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result_vector !== ID_EXP || saturated !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%b result=%h sat=%b in_ready=%b, required 1 %h 0 0",
                 i, out_valid, result_vector, saturated, in_ready, ID_EXP);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_no_accept: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    load_fill(8'd127, 8'd127);
    wait_ready();
    in_valid = 1'b1;
    @(posedge clk); #1;
    load_identity();
    wait_out(lat);
    checks++;
    if (lat !== 10 || result_vector !== POS_EXP || saturated !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: lat=%0d result=%h sat=%b, required 10 %h 1",
               lat, result_vector, saturated, POS_EXP);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle_cycle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second_accept: in_ready=%b, required 0", in_ready);
    end
    wait_out(lat);
    checks++;
    if (lat !== 10 || result_vector !== ID_EXP || saturated !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: lat=%0d result=%h sat=%b, required 10 %h 0",
               lat, result_vector, saturated, ID_EXP);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    load_fill(8'd127, 8'd127);
    do_accept();
    repeat (7) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result_vector !== 64'd0 || in_ready !== 1'b1 || saturated !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_abort: out_valid=%b result=%h in_ready=%b sat=%b, required 0 0 1 0",
               out_valid, result_vector, in_ready, saturated);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    load_identity();
    do_accept();
    wait_out(lat);
    checks++;
    if (lat !== 10 || result_vector !== ID_EXP || saturated !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_fresh: lat=%0d result=%h sat=%b, required 10 %h 0",
               lat, result_vector, saturated, ID_EXP);
    end
    consume();
  endtask

  task automatic test_bias();
    int lat;
    logic [63:0] exp_v;
    matrix = '0;
    vector = {8'd16, 8'd32, 8'd48, 8'd64};
`ifdef MVM_BIAS_EN
    for (int r = 0; r < ROWS; r++) bias[8*(ROWS - r) - 1 -: 8] = 8'(16 * r);
    exp_v = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
`else
    exp_v = 64'd0;
`endif
    do_accept();
`ifdef MVM_BIAS_EN
    bias = '0;
`endif
    wait_out(lat);
    checks++;
    if (lat !== 10 || result_vector !== exp_v || saturated !== 1'b0) begin
      failures++;
      $display("FAIL bias_result: lat=%0d result=%h sat=%b, required 10 %h 0",
               lat, result_vector, saturated, exp_v);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_bias();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
